// File: rtl/sw_deb_pkg.sv
// Shared constants, event-state type and threshold helper for the switch debouncer.
// SW_DEB_FAST_SIM_EN forces a short debounce threshold for fast simulation builds.
package sw_deb_pkg;

    localparam int SW_WIDTH           = 16;
    localparam int CLK_HZ             = 100_000_000;
    localparam int DEB_MS             = 10;
    localparam int DEB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEB_MS;
    localparam int FAST_SIM_CYCLES    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } evt_state_e;

    function automatic int deb_threshold(input int cycles);
`ifdef SW_DEB_FAST_SIM_EN
        return FAST_SIM_CYCLES;
`else
        return cycles;
`endif
    endfunction

endpackage

// File: rtl/sw_deb_chan.sv
// One switch channel: synchroniser chain, stability counter, debounced level and edge pulses.
// Threshold comes from deb_threshold(), which honours SW_DEB_FAST_SIM_EN.
module sw_deb_chan
    import sw_deb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic db_next_o,
    output logic chg_o
);

    localparam int THRESH = deb_threshold(DEBOUNCE_CYCLES);
    localparam int CW     = $clog2(THRESH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_s;
    logic                   tog_s;

    // Next-state: shift synchroniser, count disagreement, toggle on the final count.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
        s_s    = sync_q[SYNC_STAGES-1];
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        tog_s  = 1'b0;
        if (s_s != db_q) begin
            if (cnt_q == CW'(THRESH - 1)) begin
                tog_s  = 1'b1;
                db_d   = ~db_q;
                rise_d = ~db_q;
                fall_d = db_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_o      = db_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    // Pre-edge view lets the event logic capture the snapshot in the same cycle as the pulse.
    assign db_next_o = db_d;
    assign chg_o     = tog_s;

endmodule

// File: rtl/sw_debounce_evt.sv
// Debounced switch bank with rise/fall pulses and a valid/ready snapshot event channel.
// Define SW_DEB_FAST_SIM_EN to shorten the debounce threshold for simulation.
module sw_debounce_evt
    import sw_deb_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_overflow
);

    logic [WIDTH-1:0] db_next_s;
    logic [WIDTH-1:0] chg_s;
    logic             change_s;

    evt_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        sw_deb_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk_i     (CLK),
            .rst_i     (RST),
            .sw_i      (sw[gi]),
            .db_o      (sw_db[gi]),
            .rise_o    (rise[gi]),
            .fall_o    (fall[gi]),
            .db_next_o (db_next_s[gi]),
            .chg_o     (chg_s[gi])
        );
    end

    assign change_s = |chg_s;

    // Event FSM: capture a snapshot, hold it until accepted, flag changes lost while waiting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (change_s) begin
                    state_d = PEND;
                    data_d  = db_next_s;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (evt_ready) begin
                    if (change_s) begin
                        data_d = db_next_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (change_s) begin
                    ovf_d = 1'b1;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == PEND);
    end

    // Event state and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid    = valid_q;
    assign evt_data     = data_q;
    assign evt_overflow = ovf_q;

endmodule

// File: doc/sw_debounce_evt.md
Name: sw_debounce_evt

Overview:
- Input-side counterpart to the board LED drivers: samples the 16 raw slide switches, synchronises and debounces each bit, and produces clean levels plus one-cycle rise/fall pulses.
- Publishes every debounced change as a snapshot event on a valid/ready interface.
- The downstream consumer is user logic or a status FIFO.
- Sits directly behind the `sw` top-level pins, one instance per design.

Parameters:
- WIDTH, 16, number of switch channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level is accepted (10 ms at 100 MHz); legal range ≥2.
- SYNC_STAGES, 2, synchroniser flop depth per channel; legal range ≥2.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- sw  in  WIDTH  raw asynchronous switch inputs.
- sw_db  out  WIDTH  debounced switch levels.
- rise  out  WIDTH  one-cycle pulse per bit on debounced 0→1.
- fall  out  WIDTH  one-cycle pulse per bit on debounced 1→0.
- evt_valid  out  1  snapshot event pending.
- evt_ready  in  1  consumer accepts event.
- evt_data  out  WIDTH  sw_db value captured at event time.
- evt_overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (RST high at a CLK edge): all synchroniser flops, sw_db, rise, fall, evt_valid, evt_data, evt_overflow and counters go to 0. RST overrides all other activity, including an in-progress count or a pending event.
- Synchroniser: SYNC_STAGES flops per bit; s = last stage.
- Per channel, counter width = $clog2(DEBOUNCE_CYCLES):
  - s == sw_db[i]: counter cleared.
  - s != sw_db[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != sw_db[i] and counter == DEBOUNCE_CYCLES-1: sw_db[i] toggles next edge, counter cleared, rise[i]/fall[i] asserted for exactly that cycle (registered, aligned with the new sw_db).
  - Any glitch back to the accepted level restarts the count from 0. The counter never wraps.
- Latency: a raw step held stable appears on sw_db exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first sampling edge.
- Post-reset: switches already high are treated as changes. They produce rise pulses and an event after the normal latency.
- Event FSM, states IDLE and PEND:
  - A change is any bit of (rise|fall) set in a cycle.
  - IDLE, change: evt_data ← new sw_db, evt_valid=1 → PEND.
  - PEND, evt_ready & no change: evt_valid=0 → IDLE.
  - PEND, evt_ready & change in the same cycle: evt_data reloads, stays PEND.
  - PEND, !evt_ready & change: evt_data held stable (it is never modified while valid and unaccepted), change dropped, evt_overflow ← 1.
- Multiple bits changing in one cycle form one event.
- evt_overflow is cleared only by RST.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: SW_DEB_FAST_SIM_EN.
- Defined: the effective debounce threshold is forced to 4 cycles regardless of DEBOUNCE_CYCLES, and the counter width shrinks accordingly. This exists for fast simulation and directed tests.
- Undefined: DEBOUNCE_CYCLES is used as specified. Synthesis builds never define it.

Decomposition:
- Package sw_deb_pkg:
  - SW_WIDTH=16
  - CLK_HZ=100_000_000
  - DEB_MS=10
  - derived DEB_CYCLES_DEFAULT
  - FAST_SIM_CYCLES=4
  - event-state enum {IDLE, PEND}
- Sub-module sw_deb_chan: one-bit synchroniser + counter + level/rise/fall. Instantiated WIDTH times via generate. The top owns the event FSM and overflow flag.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, and macro undefined unless stated.)
1. Reset then sw=16'h0001 held → sw_db[0]=1 and rise[0]=1 for one cycle exactly 10 cycles later. evt_valid=1 with evt_data=16'h0001 on the same cycle.
2. sw[3] toggles every 5 cycles for 60 cycles → sw_db stays 0, no rise/fall, evt_valid stays 0.
3. sw=16'h00F0 step with evt_ready=1 → one event, evt_data=16'h00F0. evt_valid drops the cycle after acceptance. rise=16'h00F0 for one cycle.
4. evt_ready=0; step sw to 16'h0001, then 16'h0003 after 20 cycles → evt_data stays 16'h0001 and evt_overflow=1. After evt_ready=1, evt_valid clears and overflow stays 1 until RST.
5. RST asserted for 1 cycle at counter value 5 of a pending transition → all outputs 0 next cycle. The transition is re-qualified after a full 10 cycles.
6. SW_DEB_FAST_SIM_EN defined, DEBOUNCE_CYCLES=1000000, sw[15] 0→1 → sw_db[15]=1 after 6 cycles.
